// File: rtl/grid_move_ctrl.sv
// Tile-locked sprite movement controller: samples a direction key, asks the
// map whether the target tile is walkable, then glides one tile per step.
module grid_move_ctrl #(
  parameter int TILE_SIZE   = 16,
  parameter int STEP_SIZE   = 1,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       walk_ok,
  input  logic       walk_ack,
  output logic       walk_req,
  output logic [5:0] walk_tx,
  output logic [5:0] walk_ty,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [9:0] PlayerS,
  output logic [1:0] facing,
  output logic       moving,
  output logic [1:0] anim_frame,
  output logic       bump
);

  localparam int TSH   = $clog2(TILE_SIZE);
  localparam int STEPS = TILE_SIZE / STEP_SIZE;
  localparam int SCW   = $clog2(STEPS + 1);
  localparam int TCW   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SCW-1:0] LAST_STEP   = SCW'(STEPS - 1);
  localparam logic [TCW-1:0] LAST_WAIT   = TCW'(ACK_TIMEOUT - 1);
  localparam logic [10:0]    TILE11      = 11'(TILE_SIZE);
  localparam logic [10:0]    TWO_TILE_M1 = 11'(2 * TILE_SIZE - 1);
  localparam logic [10:0]    XMAX11      = 11'(X_MAX);
  localparam logic [10:0]    YMAX11      = 11'(Y_MAX);
  localparam logic [9:0]     TILE10      = 10'(TILE_SIZE);
  localparam logic [9:0]     STEP10      = 10'(STEP_SIZE);
  localparam logic [9:0]     START_X10   = 10'(START_X);
  localparam logic [9:0]     START_Y10   = 10'(START_Y);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUERY = 2'd1,
    S_MOVE  = 2'd2
  } state_t;

  // {valid, facing code}: 0 down, 1 up, 2 left, 3 right
  function automatic logic [2:0] decode_key(input logic [7:0] k);
    case (k)
      8'h16:   decode_key = 3'b100;
      8'h1A:   decode_key = 3'b101;
      8'h04:   decode_key = 3'b110;
      8'h07:   decode_key = 3'b111;
      default: decode_key = 3'b000;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [9:0]     player_x_q, player_x_d;
  logic [9:0]     player_y_q, player_y_d;
  logic [1:0]     facing_q, facing_d;
  logic           moving_q, moving_d;
  logic [1:0]     anim_q, anim_d;
  logic           walk_req_q, walk_req_d;
  logic [5:0]     walk_tx_q, walk_tx_d;
  logic [5:0]     walk_ty_q, walk_ty_d;
  logic           bump_q, bump_d;
  logic [TCW-1:0] wait_q, wait_d;
  logic [SCW-1:0] step_q, step_d;

  logic [2:0]  key_s;
  logic [10:0] x11_s, y11_s, tgt_x_s, tgt_y_s;
  logic        blocked_s;

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    player_x_d = player_x_q;
    player_y_d = player_y_q;
    facing_d   = facing_q;
    moving_d   = moving_q;
    anim_d     = anim_q;
    walk_req_d = walk_req_q;
    walk_tx_d  = walk_tx_q;
    walk_ty_d  = walk_ty_q;
    bump_d     = 1'b0;
    wait_d     = wait_q;
    step_d     = step_q;

    key_s     = decode_key(keycode);
    x11_s     = {1'b0, player_x_q};
    y11_s     = {1'b0, player_y_q};
    tgt_x_s   = x11_s;
    tgt_y_s   = y11_s;
    blocked_s = 1'b0;

    // Bounds are judged against the far edge of the target tile, without wrap
    case (key_s[1:0])
      2'd0: begin
        tgt_y_s   = y11_s + TILE11;
        blocked_s = (y11_s + TWO_TILE_M1) > YMAX11;
      end
      2'd1: begin
        tgt_y_s   = y11_s - TILE11;
        blocked_s = y11_s < TILE11;
      end
      2'd2: begin
        tgt_x_s   = x11_s - TILE11;
        blocked_s = x11_s < TILE11;
      end
      2'd3: begin
        tgt_x_s   = x11_s + TILE11;
        blocked_s = (x11_s + TWO_TILE_M1) > XMAX11;
      end
      default: blocked_s = 1'b1;
    endcase

    case (state_q)
      S_IDLE: begin
        moving_d = 1'b0;
        if (key_s[2]) begin
          facing_d = key_s[1:0];
          if (blocked_s) begin
            bump_d = 1'b1;
          end else begin
            state_d    = S_QUERY;
            walk_req_d = 1'b1;
            walk_tx_d  = 6'(tgt_x_s >> TSH);
            walk_ty_d  = 6'(tgt_y_s >> TSH);
            wait_d     = '0;
          end
        end else begin
          walk_req_d = 1'b0;
        end
      end

      S_QUERY: begin
        if (walk_ack) begin
          walk_req_d = 1'b0;
          if (walk_ok) begin
            state_d  = S_MOVE;
            moving_d = 1'b1;
            step_d   = '0;
          end else begin
            state_d = S_IDLE;
            bump_d  = 1'b1;
          end
        end else if (wait_q == LAST_WAIT) begin
          state_d    = S_IDLE;
          walk_req_d = 1'b0;
          bump_d     = 1'b1;
        end else begin
          wait_d = wait_q + TCW'(1);
        end
      end

      S_MOVE: begin
        case (facing_q)
          2'd0:    player_y_d = player_y_q + STEP10;
          2'd1:    player_y_d = player_y_q - STEP10;
          2'd2:    player_x_d = player_x_q - STEP10;
          2'd3:    player_x_d = player_x_q + STEP10;
          default: player_x_d = player_x_q;
        endcase
        // The final pixel update and the return to IDLE share one edge
        if (step_q == LAST_STEP) begin
          state_d  = S_IDLE;
          moving_d = 1'b0;
          anim_d   = anim_q + 2'd1;
          step_d   = '0;
        end else begin
          step_d = step_q + SCW'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        moving_d   = 1'b0;
        walk_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      player_x_q <= START_X10;
      player_y_q <= START_Y10;
      facing_q   <= 2'd0;
      moving_q   <= 1'b0;
      anim_q     <= 2'd0;
      walk_req_q <= 1'b0;
      walk_tx_q  <= 6'd0;
      walk_ty_q  <= 6'd0;
      bump_q     <= 1'b0;
      wait_q     <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      player_x_q <= player_x_d;
      player_y_q <= player_y_d;
      facing_q   <= facing_d;
      moving_q   <= moving_d;
      anim_q     <= anim_d;
      walk_req_q <= walk_req_d;
      walk_tx_q  <= walk_tx_d;
      walk_ty_q  <= walk_ty_d;
      bump_q     <= bump_d;
      wait_q     <= wait_d;
      step_q     <= step_d;
    end
  end

  assign PlayerX    = player_x_q;
  assign PlayerY    = player_y_q;
  assign PlayerS    = TILE10;
  assign facing     = facing_q;
  assign moving     = moving_q;
  assign anim_frame = anim_q;
  assign walk_req   = walk_req_q;
  assign walk_tx    = walk_tx_q;
  assign walk_ty    = walk_ty_q;
  assign bump       = bump_q;

endmodule
